// File: rtl/cpu_pkg.sv
// Shared CPU constants and helpers used by the fetch stage and the decoder.
package cpu_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'hE320F000;
  localparam logic [31:0] HALT_INSTR       = 32'hE1000070;
  localparam logic [6:0]  HALT_OPC         = 7'b0001000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // HALT is recognised by its opcode field alone, instr[27:21].
  function automatic logic is_halt(input logic [31:0] word);
    return word[27:21] == HALT_OPC;
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives a synchronous-read instruction
// memory and holds the IF/ID register feeding the decoder.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W   = 8,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [31:0]       branch_target,
  output logic              imem_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       instr,
  output logic [31:0]       instr_pc,
  output logic              instr_valid,
  output logic              halted
);

  logic [31:0] pc_q;
  logic        req_valid_q;
  logic [31:0] req_pc_q;
  logic [31:0] target;
  logic        unused_target_bits;

  assign target             = {branch_target[31:2], 2'b00};
  assign unused_target_bits = ^branch_target[1:0];

  assign imem_addr = branch_taken ? branch_target[ADDR_W+1:2] : pc_q[ADDR_W+1:2];
  assign imem_en   = !rst && (branch_taken || (!stall && !halted));

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      req_valid_q <= 1'b0;
      req_pc_q    <= '0;
      instr       <= NOP_INSTR;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else if (branch_taken) begin
      // Redirect flushes both the wrong-path IF/ID word and the data in flight.
      pc_q        <= target + 32'd4;
      req_valid_q <= 1'b1;
      req_pc_q    <= target;
      instr       <= NOP_INSTR;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else if (halted) begin
      if (!stall) begin
        instr       <= NOP_INSTR;
        instr_pc    <= '0;
        instr_valid <= 1'b0;
      end
    end else if (!stall) begin
      pc_q     <= pc_q + 32'd4;
      req_pc_q <= pc_q;
      if (req_valid_q) begin
        instr       <= imem_rdata;
        instr_pc    <= req_pc_q;
        instr_valid <= 1'b1;
        // The word fetched behind HALT is dropped by clearing the request.
        req_valid_q <= !is_halt(imem_rdata);
        halted      <= is_halt(imem_rdata);
      end else begin
        instr       <= NOP_INSTR;
        instr_pc    <= '0;
        instr_valid <= 1'b0;
        req_valid_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by random
// stall/branch/reset traffic, all compared against an address-level model.
module tb_fetch_unit;
  import cpu_pkg::*;

  localparam int unsigned ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              stall = 1'b0;
  logic              branch_taken = 1'b0;
  logic [31:0]       branch_target = '0;
  logic              imem_en;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata = '0;
  logic [31:0]       instr;
  logic [31:0]       instr_pc;
  logic              instr_valid;
  logic              halted;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] mem [256];

  // Expected architectural view: next fetch address, address in flight, IF/ID.
  logic [31:0] m_pc = 32'h0;
  logic        m_req_v = 1'b0;
  logic [31:0] m_req_pc = 32'h0;
  logic [31:0] m_instr = 32'hE320F000;
  logic [31:0] m_ipc = 32'h0;
  logic        m_iv = 1'b0;
  logic        m_halt = 1'b0;

  fetch_unit #(.ADDR_W(ADDR_W), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_en(imem_en), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .halted(halted)
  );

  always #5 clk = ~clk;

  // Synchronous-read memory that holds its output while not enabled.
  always @(posedge clk) if (imem_en) imem_rdata <= mem[imem_addr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic bubble();
    m_instr = 32'hE320F000;
    m_ipc   = 32'h0;
    m_iv    = 1'b0;
  endtask

  task automatic cycle(input logic r, input logic s, input logic b, input logic [31:0] t);
    logic [31:0] tgt;
    logic [31:0] fp;
    logic        exp_en;
    logic        is_h;
    rst = r; stall = s; branch_taken = b; branch_target = t;
    #1;
    tgt    = {t[31:2], 2'b00};
    fp     = b ? tgt : m_pc;
    exp_en = !r && (b || (!s && !m_halt));
    chk("imem_en", {31'b0, imem_en}, {31'b0, exp_en});
    if (exp_en) chk("imem_addr", {24'b0, imem_addr}, {24'b0, fp[9:2]});
    @(posedge clk);
    if (r) begin
      m_pc = 32'h0; m_req_v = 1'b0; m_req_pc = 32'h0; m_halt = 1'b0;
      bubble();
    end else if (b) begin
      bubble();
      m_halt = 1'b0; m_req_v = 1'b1; m_req_pc = tgt; m_pc = tgt + 32'd4;
    end else if (m_halt) begin
      if (!s) bubble();
    end else if (!s) begin
      if (m_req_v) begin
        m_instr = mem[m_req_pc[9:2]]; m_ipc = m_req_pc; m_iv = 1'b1;
      end else begin
        bubble();
      end
      is_h     = m_iv && (m_instr[27:21] == 7'b0001000);
      m_halt   = is_h;
      m_req_v  = !is_h;
      m_req_pc = m_pc;
      m_pc     = m_pc + 32'd4;
    end
    #1;
    chk("instr", instr, m_instr);
    chk("instr_pc", instr_pc, m_ipc);
    chk("instr_valid", {31'b0, instr_valid}, {31'b0, m_iv});
    chk("halted", {31'b0, halted}, {31'b0, m_halt});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    for (int k = 0; k < 256; k++) mem[k] = 32'hE2800000 | k;
    mem[8] = HALT_INSTR;

    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    chk("reset_instr", instr, 32'hE320F000);
    chk("reset_valid", {31'b0, instr_valid}, 32'h0);

    run(1);
    chk("first_bubble", {31'b0, instr_valid}, 32'h0);
    run(3);
    chk("seq_pc8", instr_pc, 32'h8);
    chk("seq_word2", instr, 32'hE2800002);

    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 32'h0);
    chk("stall_hold", instr_pc, 32'h8);
    run(2);
    chk("after_stall", instr_pc, 32'h10);

    cycle(1'b0, 1'b0, 1'b1, 32'h40);
    chk("br_bubble", instr, 32'hE320F000);
    run(1);
    chk("br_target", instr_pc, 32'h40);
    run(1);
    chk("br_next", instr_pc, 32'h44);

    cycle(1'b0, 1'b1, 1'b1, 32'h43);
    run(1);
    chk("br_unaligned_stall", instr_pc, 32'h40);
    run(1);

    cycle(1'b0, 1'b0, 1'b1, 32'h10);
    run(5);
    chk("halt_word", instr, HALT_INSTR);
    chk("halt_raised", {31'b0, halted}, 32'h1);
    run(2);
    for (int i = 0; i < 2; i++) cycle(1'b0, 1'b1, 1'b0, 32'h0);
    run(1);
    cycle(1'b0, 1'b0, 1'b1, 32'h0);
    chk("halt_cleared", {31'b0, halted}, 32'h0);
    run(4);

    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    run(3);
    chk("restart_pc", instr_pc, 32'h4);

    cycle(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    run(1);
    chk("wrap_top", instr_pc, 32'hFFFF_FFFC);
    run(1);
    chk("wrap_zero", instr_pc, 32'h0);

    // Random phase: fresh memory image with scattered HALT and NOP words.
    for (int k = 0; k < 256; k++) begin
      if ($urandom_range(0, 19) == 0)      mem[k] = HALT_INSTR;
      else if ($urandom_range(0, 9) == 0)  mem[k] = NOP_INSTR;
      else                                 mem[k] = $urandom;
    end
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3000; i++) begin
      logic        r, s, b;
      logic [31:0] t;
      r = ($urandom_range(0, 299) == 0);
      s = ($urandom_range(0, 4) == 0);
      b = ($urandom_range(0, 11) == 0);
      t = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : 32'($urandom_range(0, 1023));
      cycle(r, s, b, t);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
